// File: rtl/act_quant_pack_if.sv
`default_nettype none
// ============================================================================
//  Module   : act_quant_pack_if
//  Brief    : Bias-data input beat and output feature RAM write port bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface act_quant_pack_if #(
   parameter int LANES          = 32,
   parameter int IN_W           = 16,
   parameter int OUT_W          = 8,
   parameter int RAM_ADDR_WIDTH = 8
);
   logic [LANES*IN_W-1:0]      bias_dat;
   logic                       bias_dat_vld;
   logic                       ram_wr_en;
   logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
   logic [2*LANES*OUT_W-1:0]   ram_dat;

   // master = beat producer / RAM observer, slave = the quantize-and-pack stage
   modport master (output bias_dat, bias_dat_vld, input ram_wr_en, ram_addr, ram_dat);
   modport slave  (input bias_dat, bias_dat_vld, output ram_wr_en, ram_addr, ram_dat);
endinterface
`default_nettype wire

// File: rtl/act_quant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : act_quant_pack
//  Brief    : ReLU + rounding shift + saturate to 8b per lane, pack two beats
//             per 512b word and write them to sequential output RAM addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module act_quant_pack #(
   parameter int LANES          = 32,
   parameter int IN_W           = 16,
   parameter int OUT_W          = 8,
   parameter int RAM_ADDR_WIDTH = 8
) (
   input  wire logic                      i_clk,
   input  wire logic                      i_rst_n,
   input  wire logic                      i_start,
   input  wire logic                      i_relu_en,
   input  wire logic [3:0]                i_shift,
   input  wire logic [RAM_ADDR_WIDTH-1:0] i_addr_start_o,
   input  wire logic [7:0]                i_word_num,
   act_quant_pack_if.slave                bus,
   output logic                           o_busy,
   output logic                           o_done
);
   localparam int                 c_beat_w = LANES*OUT_W;
   localparam logic signed [IN_W:0] c_one  = (IN_W+1)'(1);
   localparam logic signed [IN_W:0] c_max  = (IN_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [IN_W:0] c_min  = -(IN_W+1)'(2**(OUT_W-1));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                      r_state, w_next;
   logic                        r_relu_en;
   logic [3:0]                  r_shift;
   logic [7:0]                  r_word_num;
   logic [7:0]                  r_wr_cnt;
   logic [8:0]                  r_beat_cnt;
   logic [RAM_ADDR_WIDTH-1:0]   r_wr_addr;
   logic                        r_s1_vld;
   logic [c_beat_w-1:0]         r_s1_dat;
   logic                        r_half;
   logic [c_beat_w-1:0]         r_hold;
   logic                        r_ram_wr_en;
   logic [RAM_ADDR_WIDTH-1:0]   r_ram_addr;
   logic [2*c_beat_w-1:0]       r_ram_dat;
   logic [c_beat_w-1:0]         w_q_dat;
   logic                        w_accept;

   // The extra sum bit keeps the rounding offset from overflowing at +max.
   function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x,
                                              input logic relu,
                                              input logic [3:0] s);
      logic signed [IN_W:0] v;
      logic signed [IN_W:0] y;
      v = (relu && x < 0) ? '0 : {x[IN_W-1], x};
      if (s == 4'd0) y = v;
      else           y = (v + (c_one <<< (s - 4'd1))) >>> s;
      if (y > c_max)      quant = c_max[OUT_W-1:0];
      else if (y < c_min) quant = c_min[OUT_W-1:0];
      else                quant = y[OUT_W-1:0];
   endfunction

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_q_dat[k*OUT_W +: OUT_W] = quant(bus.bias_dat[k*IN_W +: IN_W], r_relu_en, r_shift);
   end

   // Beats beyond the programmed word count never enter the pipeline.
   assign w_accept = bus.bias_dat_vld && (r_state == S_RUN) && (r_beat_cnt < {r_word_num, 1'b0});

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_IDLE: if (i_start) w_next = S_RUN;
         S_RUN: begin
            o_busy = 1'b1;
            if (r_wr_cnt == r_word_num && !r_s1_vld) w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_relu_en   <= 1'b0;
         r_shift     <= '0;
         r_word_num  <= '0;
         r_wr_cnt    <= '0;
         r_beat_cnt  <= '0;
         r_wr_addr   <= '0;
         r_s1_vld    <= 1'b0;
         r_s1_dat    <= '0;
         r_half      <= 1'b0;
         r_hold      <= '0;
         r_ram_wr_en <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_dat   <= '0;
      end else begin
         r_ram_wr_en <= 1'b0;
         r_s1_vld    <= w_accept;
         if (r_state == S_IDLE && i_start) begin
            r_relu_en  <= i_relu_en;
            r_shift    <= i_shift;
            r_word_num <= i_word_num;
            r_wr_addr  <= i_addr_start_o;
            r_wr_cnt   <= '0;
            r_beat_cnt <= '0;
            r_half     <= 1'b0;
         end
         if (w_accept) begin
            r_s1_dat   <= w_q_dat;
            r_beat_cnt <= r_beat_cnt + 9'd1;
         end
         if (r_s1_vld) begin
            if (!r_half) begin
               r_hold <= r_s1_dat;
               r_half <= 1'b1;
            end else begin
               r_ram_dat   <= {r_s1_dat, r_hold};
               r_ram_addr  <= r_wr_addr;
               r_ram_wr_en <= 1'b1;
               r_wr_addr   <= r_wr_addr + 1'b1;
               r_wr_cnt    <= r_wr_cnt + 8'd1;
               r_half      <= 1'b0;
            end
         end
      end
   end

   assign bus.ram_wr_en = r_ram_wr_en;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_dat   = r_ram_dat;
endmodule
`default_nettype wire

// File: tb/tb_act_quant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_act_quant_pack
//  Brief    : Scoreboard bench for act_quant_pack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_act_quant_pack;
   localparam int LANES = 32;
   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int AW    = 8;
   localparam int BW_IN = LANES*IN_W;
   localparam int BW_Q  = LANES*OUT_W;

   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [2*BW_Q-1:0] dat;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            relu_en = 1'b0;
   logic [3:0]      shift = 4'd0;
   logic [AW-1:0]   addr_start = '0;
   logic [7:0]      word_num = 8'd0;
   logic            busy, done;

   wr_t             exp_q[$];
   wr_t             mon_e;
   logic [BW_Q-1:0] held_exp;
   int              checks = 0;
   int              errors = 0;
   int              n_writes = 0;
   int              n_done = 0;

   act_quant_pack_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .RAM_ADDR_WIDTH(AW)) bus ();

   act_quant_pack #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .RAM_ADDR_WIDTH(AW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_relu_en      (relu_en),
      .i_shift        (shift),
      .i_addr_start_o (addr_start),
      .i_word_num     (word_num),
      .bus            (bus.slave),
      .o_busy         (busy),
      .o_done         (done)
   );

   always #5 clk = ~clk;

   // Floor-division reference for the rounding shift.
   function automatic logic [7:0] model_q(input int x, input bit relu, input int s);
      int v, d, q;
      v = (relu && x < 0) ? 0 : x;
      if (s == 0) q = v;
      else begin
         d = 1 << s;
         v = v + d / 2;
         q = v / d;
         if ((v % d) != 0 && v < 0) q = q - 1;
      end
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   function automatic logic [BW_Q-1:0] model_beat(input logic [BW_IN-1:0] d, input bit relu, input int s);
      logic [BW_Q-1:0]        r;
      logic signed [IN_W-1:0] x;
      for (int k = 0; k < LANES; k++) begin
         x = d[k*IN_W +: IN_W];
         r[k*OUT_W +: OUT_W] = model_q(int'(x), relu, s);
      end
      return r;
   endfunction

   function automatic logic [BW_IN-1:0] rand_beat();
      logic [BW_IN-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = 16'($urandom);
      return d;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) n_done++;
      if (bus.ram_wr_en === 1'b1) begin
         n_writes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h dat=%h", bus.ram_addr, bus.ram_dat);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.ram_addr !== mon_e.addr || bus.ram_dat !== mon_e.dat) begin
               errors++;
               $display("FAIL ram_write got addr=%h dat=%h exp addr=%h dat=%h",
                        bus.ram_addr, bus.ram_dat, mon_e.addr, mon_e.dat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input bit relu, input logic [3:0] s, input logic [AW-1:0] a, input logic [7:0] n);
      relu_en = relu; shift = s; addr_start = a; word_num = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [BW_IN-1:0] d, input bit second, input logic [AW-1:0] a);
      wr_t e;
      bus.bias_dat = d;
      bus.bias_dat_vld = 1'b1;
      if (!second) held_exp = model_beat(d, relu_en, int'(shift));
      else begin
         e.addr = a;
         e.dat  = {model_beat(d, relu_en, int'(shift)), held_exp};
         exp_q.push_back(e);
      end
      tick();
      bus.bias_dat_vld = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout done=%b exp=1", name, done);
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus.ram_wr_en !== 1'b0 || bus.ram_addr !== '0 || bus.ram_dat !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs wr=%b addr=%h busy=%b done=%b exp all 0", bus.ram_wr_en, bus.ram_addr, busy, done);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [BW_IN-1:0] b0;
      b0 = rand_beat();
      b0[0*IN_W +: IN_W] = 16'(5);
      b0[1*IN_W +: IN_W] = 16'(-7);
      b0[2*IN_W +: IN_W] = 16'(200);
      b0[3*IN_W +: IN_W] = 16'(-300);
      start_run(1'b0, 4'd0, 8'h10, 8'd1);
      send_beat(b0, 1'b0, 8'h10);
      send_beat(rand_beat(), 1'b1, 8'h10);
      checks++;
      if (bus.ram_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency_t1 wr_en=%b exp=0", bus.ram_wr_en);
      end
      tick();
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_addr !== 8'h10 || bus.ram_dat[31:0] !== 32'h807F_F905) begin
         errors++;
         $display("FAIL basic_write_t2 wr_en=%b addr=%h low=%h exp 1 10 807ff905",
                  bus.ram_wr_en, bus.ram_addr, bus.ram_dat[31:0]);
      end
      wait_done("basic");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle busy=%b exp=0", busy);
      end
   endtask

   task automatic test_relu_shift();
      logic [BW_IN-1:0] b1;
      b1 = rand_beat();
      b1[0*IN_W +: IN_W] = 16'(-8);
      b1[1*IN_W +: IN_W] = 16'(6);
      b1[2*IN_W +: IN_W] = 16'(5);
      b1[3*IN_W +: IN_W] = 16'(1023);
      start_run(1'b1, 4'd2, 8'h20, 8'd1);
      send_beat(rand_beat(), 1'b0, 8'h20);
      send_beat(b1, 1'b1, 8'h20);
      tick();
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_dat[287:256] !== 32'h7F01_0200) begin
         errors++;
         $display("FAIL relu_shift got wr=%b hi=%h exp 1 7f010200", bus.ram_wr_en, bus.ram_dat[287:256]);
      end
      wait_done("relu_shift");
   endtask

   task automatic test_round();
      logic [BW_IN-1:0] b;
      b = rand_beat();
      b[0 +: IN_W] = 16'(-3);
      start_run(1'b0, 4'd1, 8'h30, 8'd1);
      send_beat(b, 1'b0, 8'h30);
      send_beat(rand_beat(), 1'b1, 8'h30);
      tick();
      checks++;
      if (bus.ram_dat[7:0] !== 8'hFF) begin
         errors++;
         $display("FAIL round_neg3_s1 got=%h exp=ff", bus.ram_dat[7:0]);
      end
      wait_done("round_a");
      b = rand_beat();
      b[0 +: IN_W]    = 16'h7FFF;
      b[IN_W +: IN_W] = 16'h8000;
      start_run(1'b0, 4'd15, 8'h31, 8'd1);
      send_beat(b, 1'b0, 8'h31);
      send_beat(rand_beat(), 1'b1, 8'h31);
      tick();
      checks++;
      if (bus.ram_dat[15:0] !== 16'hFF01) begin
         errors++;
         $display("FAIL round_s15 got=%h exp=ff01", bus.ram_dat[15:0]);
      end
      wait_done("round_b");
   endtask

   task automatic test_back_to_back();
      int w0, d0;
      logic [AW-1:0] a;
      w0 = n_writes;
      d0 = n_done;
      a  = 8'hFE;
      start_run(1'b0, 4'd3, 8'hFE, 8'd3);
      for (int i = 0; i < 6; i++) begin
         send_beat(rand_beat(), i[0], a);
         if (i[0]) a = a + 8'd1;
      end
      wait_done("b2b");
      repeat (4) tick();
      checks++;
      if (n_writes - w0 !== 3 || n_done - d0 !== 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_counts writes=%0d dones=%0d pending=%0d exp 3 1 0", n_writes - w0, n_done - d0, exp_q.size());
      end
   endtask

   task automatic test_zero_words();
      int w0;
      w0 = n_writes;
      start_run(1'b0, 4'd0, 8'h50, 8'd0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL zero_c1 busy=%b done=%b exp 1 0", busy, done);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL zero_c2 busy=%b done=%b exp 0 1", busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || n_writes != w0) begin
         errors++;
         $display("FAIL zero_c3 done=%b writes=%0d exp 0 0", done, n_writes - w0);
      end
   endtask

   task automatic test_reset_mid_run();
      int w0;
      w0 = n_writes;
      start_run(1'b0, 4'd4, 8'h40, 8'd1);
      send_beat(rand_beat(), 1'b0, 8'h40);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      checks++;
      if (n_writes != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run writes=%0d busy=%b exp 0 0", n_writes - w0, busy);
      end
      start_run(1'b1, 4'd4, 8'h55, 8'd1);
      send_beat(rand_beat(), 1'b0, 8'h55);
      send_beat(rand_beat(), 1'b1, 8'h55);
      wait_done("restart");
      checks++;
      if (n_writes - w0 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL restart_write writes=%0d pending=%0d exp 1 0", n_writes - w0, exp_q.size());
      end
   endtask

   initial begin
      bus.bias_dat     = '0;
      bus.bias_dat_vld = 1'b0;
      test_reset();
      test_basic();
      test_relu_shift();
      test_round();
      test_back_to_back();
      test_zero_words();
      test_reset_mid_run();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
